// File: rtl/uart_autobaud_pkg.sv
// Shared types and constants for the UART auto-baud controller.
package uart_autobaud_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GUARD,
    ST_WAIT_EDGE,
    ST_MEASURE,
    ST_CALC
  } ab_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TOO_FAST = 2'b01;
  localparam logic [1:0] ERR_TOL      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Falling edges in a 0x55 sync character (start bit plus four data zeros).
  localparam logic [2:0] SYNC_EDGES = 3'd5;

endpackage

// File: rtl/uart_rx_edge_sync.sv
// Two-flop RX synchroniser plus history flop; flags a falling edge with a
// fixed latency so that edge-to-edge intervals are exact.
module uart_rx_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_rx_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Preset to 1 so an idle line never produces a spurious edge out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx_sync = r_sync;
  assign o_fall    = r_prev & ~r_sync;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: measures a 0x55 sync character on RX and derives the
// x16-oversampling divider (baud_val) and optional eighths fraction.
module uart_autobaud_ctrl
  import uart_autobaud_pkg::*;
#(
  parameter bit          BAUD_VAL_FRCTN_EN = 1'b0,
  parameter int unsigned CNT_W             = 20,
  parameter int unsigned TOL_SHIFT         = 2,
  parameter int unsigned IDLE_GUARD        = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        rx,
  output logic [12:0] baud_val,
  output logic [2:0]  baud_val_fraction,
  output logic        cfg_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned    GW       = $clog2(IDLE_GUARD + 1);
  localparam logic [CNT_W:0] BAUD_MAX = (CNT_W + 1)'(13'h1FFF);

  ab_state_t        r_state;
  logic [GW-1:0]    r_guard;
  logic [CNT_W-1:0] r_c;
  logic [CNT_W-1:0] r_ival;
  logic [CNT_W-1:0] r_i1;
  logic [2:0]       r_edge;
  logic [12:0]      r_baud;
  logic [2:0]       r_frac;
  logic             r_cfg_valid;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_code;

  logic             w_rx;
  logic             w_fall;
  logic [CNT_W-1:0] w_c_inc;
  logic [CNT_W-1:0] w_ival;
  logic [CNT_W-1:0] w_diff;
  logic [CNT_W-1:0] w_tol;
  logic             w_tol_fail;
  logic [2:0]       w_edge_nxt;
  logic [CNT_W:0]   w_c_ext;
  logic [CNT_W:0]   w_q;
  logic [CNT_W:0]   w_r;
  logic [CNT_W:0]   w_int;
  logic [CNT_W:0]   w_int_m1;
  logic             w_too_fast;
  logic [12:0]      w_baud;
  logic [2:0]       w_frac;

  uart_rx_edge_sync u_sync (
    .i_clk    (clk),
    .i_rst_n  (reset_n),
    .i_rx     (rx),
    .o_rx_sync(w_rx),
    .o_fall   (w_fall)
  );

  assign w_c_inc    = r_c + CNT_W'(1);
  // Interval includes the current cycle, so it equals the true edge spacing.
  assign w_ival     = r_ival + CNT_W'(1);
  assign w_edge_nxt = r_edge + 3'd1;
  assign w_diff     = (w_ival >= r_i1) ? (w_ival - r_i1) : (r_i1 - w_ival);
  assign w_tol      = r_i1 >> TOL_SHIFT;
  assign w_tol_fail = (w_diff > w_tol);

  assign w_c_ext    = {1'b0, r_c};
  assign w_q        = (w_c_ext + (CNT_W + 1)'(8)) >> 4;
  assign w_r        = (w_c_ext + (CNT_W + 1)'(64)) >> 7;
  assign w_int      = BAUD_VAL_FRCTN_EN ? (w_q >> 3) : w_r;
  assign w_too_fast = BAUD_VAL_FRCTN_EN ? (w_q < (CNT_W + 1)'(8)) : (w_r == '0);
  assign w_int_m1   = w_int - (CNT_W + 1)'(1);
  assign w_baud     = (w_int_m1 > BAUD_MAX) ? 13'h1FFF : w_int_m1[12:0];
  assign w_frac     = BAUD_VAL_FRCTN_EN ? w_q[2:0] : 3'b000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_guard     <= '0;
      r_c         <= '0;
      r_ival      <= '0;
      r_i1        <= '0;
      r_edge      <= '0;
      r_baud      <= '0;
      r_frac      <= '0;
      r_cfg_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !abort) begin
              r_state     <= ST_GUARD;
              r_guard     <= '0;
              r_err_code  <= ERR_NONE;
              r_cfg_valid <= 1'b0;
            end
          end
          ST_GUARD: begin
            if (!w_rx) begin
              r_guard <= '0;
            end else if (r_guard == GW'(IDLE_GUARD - 1)) begin
              r_guard <= '0;
              r_state <= ST_WAIT_EDGE;
            end else begin
              r_guard <= r_guard + GW'(1);
            end
          end
          ST_WAIT_EDGE: begin
            if (w_fall) begin
              r_c     <= '0;
              r_ival  <= '0;
              r_edge  <= 3'd1;
              r_state <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            r_c    <= w_c_inc;
            r_ival <= w_ival;
            if (w_c_inc == '1) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_TIMEOUT;
              r_state    <= ST_IDLE;
            end else if (w_fall) begin
              r_ival <= '0;
              r_edge <= w_edge_nxt;
              if (r_edge == 3'd1) begin
                r_i1 <= w_ival;
              end else if (w_tol_fail) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_TOL;
                r_state    <= ST_IDLE;
              end else if (w_edge_nxt == SYNC_EDGES) begin
                r_state <= ST_CALC;
              end
            end
          end
          ST_CALC: begin
            r_state <= ST_IDLE;
            if (w_too_fast) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_TOO_FAST;
            end else begin
              r_baud      <= w_baud;
              r_frac      <= w_frac;
              r_cfg_valid <= 1'b1;
              r_done      <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign baud_val          = r_baud;
  assign baud_val_fraction = r_frac;
  assign cfg_valid         = r_cfg_valid;
  assign busy              = (r_state != ST_IDLE);
  assign done              = r_done;
  assign err               = r_err;
  assign err_code          = r_err_code;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed bench for uart_autobaud_ctrl: fractional, integer-only and
// narrow-counter instances share one RX line and one control interface.
module tb_uart_autobaud_ctrl;

  logic clk = 1'b0;
  logic reset_n, start, abort, rx;

  logic [12:0] a_baud, z_baud, t_baud;
  logic [2:0]  a_frac, z_frac, t_frac;
  logic        a_cfgv, z_cfgv, t_cfgv;
  logic        a_busy, z_busy, t_busy;
  logic        a_done, z_done, t_done;
  logic        a_err,  z_err,  t_err;
  logic [1:0]  a_ec,   z_ec,   t_ec;

  int n_total = 0;
  int n_bad   = 0;
  int a_ndone = 0, a_nerr = 0, z_ndone = 0, z_nerr = 0, t_ndone = 0;

  always #5 clk = ~clk;

  uart_autobaud_ctrl #(.BAUD_VAL_FRCTN_EN(1'b1), .CNT_W(20)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .rx(rx),
    .baud_val(a_baud), .baud_val_fraction(a_frac), .cfg_valid(a_cfgv),
    .busy(a_busy), .done(a_done), .err(a_err), .err_code(a_ec)
  );

  uart_autobaud_ctrl #(.BAUD_VAL_FRCTN_EN(1'b0), .CNT_W(20)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .rx(rx),
    .baud_val(z_baud), .baud_val_fraction(z_frac), .cfg_valid(z_cfgv),
    .busy(z_busy), .done(z_done), .err(z_err), .err_code(z_ec)
  );

  uart_autobaud_ctrl #(.BAUD_VAL_FRCTN_EN(1'b1), .CNT_W(12)) u_dut12 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .rx(rx),
    .baud_val(t_baud), .baud_val_fraction(t_frac), .cfg_valid(t_cfgv),
    .busy(t_busy), .done(t_done), .err(t_err), .err_code(t_ec)
  );

  always @(negedge clk) begin
    if (a_done) a_ndone++;
    if (a_err)  a_nerr++;
    if (z_done) z_ndone++;
    if (z_err)  z_nerr++;
    if (t_done) t_ndone++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; drive v and keep it for n clock cycles.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // 0x55 framed LSB first; data bit 3 (a low bit) lasts t3 cycles.
  task automatic send_55(input int t, input int t3);
    logic [7:0] pat;
    pat = 8'h55;
    @(negedge clk);
    hold(1'b0, t);
    for (int b = 0; b < 8; b++) hold(pat[b], (b == 3) ? t3 : t);
    hold(1'b1, t);
  endtask

  task automatic arm();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  task automatic settle();
    repeat (30) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d_a, e_a, d_z, e_z, d_t, n;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_baud", a_baud, 0);
    chk("rst_frac", a_frac, 0);
    chk("rst_cfgv", a_cfgv, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err",  a_err, 0);
    chk("rst_ec",   a_ec, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: nominal 96-cycle bit, C=768
    d_a = a_ndone; e_a = a_nerr; d_z = z_ndone; d_t = t_ndone;
    arm();
    chk("t1_busy", a_busy, 1);
    send_55(96, 96);
    settle();
    chk("t1_done_cnt", a_ndone - d_a, 1);
    chk("t1_err_cnt", a_nerr - e_a, 0);
    chk("t1_baud", a_baud, 5);
    chk("t1_frac", a_frac, 0);
    chk("t1_cfgv", a_cfgv, 1);
    chk("t1_ec", a_ec, 0);
    chk("t1_busy_end", a_busy, 0);
    chk("t1_z_done_cnt", z_ndone - d_z, 1);
    chk("t1_z_baud", z_baud, 5);
    chk("t1_t_done_cnt", t_ndone - d_t, 1);
    chk("t1_t_baud", t_baud, 5);
    chk("t1_t_frac", t_frac, 0);

    // 2: 102-cycle bit, C=816, Q=51, R=6
    d_a = a_ndone; d_z = z_ndone;
    arm();
    chk("t2_cfgv_clr", a_cfgv, 0);
    send_55(102, 102);
    settle();
    chk("t2_done_cnt", a_ndone - d_a, 1);
    chk("t2_baud", a_baud, 5);
    chk("t2_frac", a_frac, 3);
    chk("t2_z_done_cnt", z_ndone - d_z, 1);
    chk("t2_z_baud", z_baud, 5);
    chk("t2_z_frac", z_frac, 0);
    chk("t2_z_cfgv", z_cfgv, 1);

    // 3: 7-cycle bit, C=56 -> too fast for both rounding modes
    d_a = a_ndone; e_a = a_nerr; e_z = z_nerr;
    arm();
    send_55(7, 7);
    settle();
    chk("t3_err_cnt", a_nerr - e_a, 1);
    chk("t3_done_cnt", a_ndone - d_a, 0);
    chk("t3_ec", a_ec, 1);
    chk("t3_cfgv", a_cfgv, 0);
    chk("t3_baud_kept", a_baud, 5);
    chk("t3_frac_kept", a_frac, 3);
    chk("t3_z_err_cnt", z_nerr - e_z, 1);
    chk("t3_z_ec", z_ec, 1);
    chk("t3_z_baud_kept", z_baud, 5);

    // 4a: bit 3 stretched to 144 -> interval 240, |240-192| = 48 = limit, accepted
    d_a = a_ndone; e_a = a_nerr;
    arm();
    chk("t4a_ec_clr", a_ec, 0);
    send_55(96, 144);
    settle();
    chk("t4a_done_cnt", a_ndone - d_a, 1);
    chk("t4a_err_cnt", a_nerr - e_a, 0);
    chk("t4a_baud", a_baud, 5);
    chk("t4a_frac", a_frac, 3);

    // 4b: bit 3 stretched to 160 -> interval 256, deviation 64 > 48
    d_a = a_ndone; e_a = a_nerr; e_z = z_nerr;
    arm();
    send_55(96, 160);
    settle();
    chk("t4b_err_cnt", a_nerr - e_a, 1);
    chk("t4b_done_cnt", a_ndone - d_a, 0);
    chk("t4b_ec", a_ec, 2);
    chk("t4b_cfgv", a_cfgv, 0);
    chk("t4b_baud_kept", a_baud, 5);
    chk("t4b_z_ec", z_ec, 2);

    // 5: single fall then idle line; 12-bit counter saturates
    arm();
    chk("t5_busy12", t_busy, 1);
    @(posedge clk);
    #1;
    rx = 1'b0;
    n = 0;
    for (int k = 1; k <= 5000; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) rx = 1'b1;
      if (t_err) begin
        n = k;
        break;
      end
    end
    chk("t5_tmo_latency", n, 4098);
    chk("t5_ec", t_ec, 3);
    chk("t5_busy_drop", t_busy, 0);
    chk("t5_cfgv", t_cfgv, 0);
    @(posedge clk);
    #1;
    chk("t5_err_1cyc", t_err, 0);
    e_a = a_nerr;
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_abort_busy", a_busy, 0);
    chk("t5_abort_z_busy", z_busy, 0);
    @(negedge clk);
    abort = 1'b0;
    settle();
    chk("t5_abort_no_err", a_nerr - e_a, 0);

    // 6a: abort in MEASURE after the third falling edge
    d_a = a_ndone; e_a = a_nerr;
    arm();
    hold(1'b0, 96);
    hold(1'b1, 96);
    hold(1'b0, 96);
    hold(1'b1, 96);
    hold(1'b0, 40);
    chk("t6a_busy_pre", a_busy, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("t6a_busy", a_busy, 0);
    chk("t6a_cfgv", a_cfgv, 0);
    @(negedge clk);
    abort = 1'b0;
    rx = 1'b1;
    settle();
    chk("t6a_done_cnt", a_ndone - d_a, 0);
    chk("t6a_err_cnt", a_nerr - e_a, 0);
    chk("t6a_baud_kept", a_baud, 5);
    chk("t6a_frac_kept", a_frac, 3);

    // 6b: start and abort together in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("t6b_busy", a_busy, 0);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1;
    chk("t6b_busy_next", a_busy, 0);

    // 6c: asynchronous reset mid-measurement
    arm();
    hold(1'b0, 96);
    hold(1'b1, 96);
    hold(1'b0, 20);
    chk("t6c_busy_pre", a_busy, 1);
    chk("t6c_baud_pre", a_baud, 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6c_baud", a_baud, 0);
    chk("t6c_frac", a_frac, 0);
    chk("t6c_busy", a_busy, 0);
    chk("t6c_cfgv", a_cfgv, 0);
    chk("t6c_ec", a_ec, 0);
    chk("t6c_z_baud", z_baud, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
